yg_dec_encoder: RTL
===================

# yg_dec_encoder

Sequential 4-to-2 priority encoder that recovers the binary select code from the four active-low output lines of the structural 2x4 negative-output, positive-enable decoder. It sits downstream of that decoder and converts each new active line into one code word on a valid/ready handshake. It also flags illegal multi-line patterns and counts delivered codes. It serves as the loop-back checker for the decoder, and as the encoder half of the decoder/encoder pair.

## Interface
Parameters:
- `CNT_W`, default 8, width of the delivered-code counter.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `en`  in  1  positive enable; when 0, all lines are treated as inactive.
- `y_n`  in  4  decoder output lines, active low; `y_n[i]=0` means line i is active.
- `code`  out  2  encoded index of the highest active line; reset 2'b00.
- `out_valid`  out  1  `code` holds an undelivered word; reset 0.
- `out_ready`  in  1  consumer accepts `code` when high together with `out_valid`.
- `any_active`  out  1  registered OR of the active lines; reset 0.
- `multi_err`  out  1  registered flag: two or more lines active in the sampled cycle; reset 0.
- `overrun`  out  1  sticky flag: a new pattern arrived while a word was pending; reset 0; cleared only by `rst`.
- `evt_count`  out  CNT_W  number of accepted handshakes, saturating; reset 0.

## Operation
- Input stage: `y_q <= y_n`, `en_q <= en` every cycle. Reset values: `y_q = 4'b1111`, `en_q = 0`.
- Active vector: `act = ~y_q & {4{en_q}}`.
- Priority: line 3 highest. `code_next` is the highest set index in `act`; it is don't-care when `act == 0`.
- `act_prev` register holds the `act` value of the last evaluated cycle; reset 0.
- New event: `act != 0` and `act != act_prev`. Holding a line steady produces exactly one event.
- FSM states:
  - IDLE:
    - `out_valid = 0`.
    - On a new event: load `code`, go to PRESENT.
  - PRESENT:
    - `out_valid = 1`; `code` is held stable.
    - On `out_ready`: increment `evt_count`, go to IDLE.
    - On a new event without `out_ready`: set `overrun`, keep the old `code`, and drop the new event.
    - On a new event in the same cycle as `out_ready`: handshake completes, the new code loads, and the FSM stays in PRESENT.
- `multi_err`: registered `popcount(act) > 1`, updated every cycle independent of the FSM. The encoded code still follows priority.
- `any_active`: registered `|act`.
- `evt_count`: saturates at `2**CNT_W-1`; further handshakes do not wrap.
- `en` low while PRESENT: the pending word is kept until accepted; `act` becomes 0 and `act_prev` follows.
- `rst` mid-operation: every register returns to its reset value on that edge. The pending word is discarded and the counter and `overrun` are cleared.

## Timing
- Latency: `y_n` sampled at edge N gives `act` valid after N. The FSM registers at N+1, so `out_valid` and `code` are visible after edge N+1. Total latency is 2 edges.
- `any_active` and `multi_err` change after edge N+1, aligned with `out_valid`.
- `code` changes only on an edge where a word loads.
- `out_valid` never drops without a handshake, except on `rst`.
- Back-to-back events are accepted one per cycle when `out_ready` is held high.

## Structure
- Package `yg_enc_pkg`:
  - state enum `enc_state_t {IDLE, PRESENT}`;
  - localparam `NUM_LINES = 4`;
  - localparam `CODE_W = 2`.
- Sub-module `yg_prio_enc4`: combinational. Input `act[3:0]`; outputs `code[1:0]`, `any`, `multi`. Instantiated once. The top level holds the input registers, FSM, counter and flags.

## Test plan
1. Reset and idle:
   - Stimulus: assert `rst` for 2 cycles with `y_n = 4'b0000`, `en = 1`, then release it while `y_n = 4'b1111` and `en = 1`.
   - Required response: all outputs are 0 during and after reset, `code = 00` and `out_valid = 0`.
2. Sweep:
   - Stimulus: `en = 1`, `out_ready = 1`. Drive `y_n` = 1110, 1101, 1011, 0111, each for 3 cycles.
   - Required response: `code` goes 00, 01, 10, 11 with exactly one `out_valid` pulse each, 2 edges after each change. `evt_count = 4`.
3. Hold and overrun:
   - Stimulus: `out_ready = 0`, `y_n = 1101`, then `y_n = 1011`.
   - Required response: `out_valid` stays 1, `code` stays 01, `overrun = 1`.
   - Stimulus: then raise `out_ready`.
   - Required response: one handshake, `evt_count` increments, and `overrun` stays 1.
4. Multi-line:
   - Stimulus: `y_n = 0110`.
   - Required response: `code = 11`, `multi_err = 1`, `any_active = 1`.
   - Stimulus: then `y_n = 1111`.
   - Required response: `multi_err = 0` after 2 edges.
5. Enable gating:
   - Stimulus: `en = 0` with `y_n = 1110`.
   - Required response: no `out_valid` and `any_active = 0`.
   - Stimulus: raise `en`.
   - Required response: `code = 00` presented once.
6. Saturation and reset:
   - Stimulus: `CNT_W = 2`, 5 events with `out_ready = 1`.
   - Required response: `evt_count = 3`.
   - Stimulus: pulse `rst` while PRESENT.
   - Required response: `out_valid`, `evt_count` and `overrun` read 0 after that edge.

Source files
------------

// File: rtl/yg_enc_pkg.sv
// Shared types and constants for the decoder loop-back encoder.
//   enc_state_t : output-word FSM states (IDLE, PRESENT)
//   NUM_LINES   : number of decoder output lines observed
//   CODE_W      : width of the recovered binary select code
package yg_enc_pkg;

  localparam int NUM_LINES = 4;
  localparam int CODE_W    = 2;

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } enc_state_t;

endpackage

// File: rtl/yg_prio_enc4.sv
// Combinational 4-to-2 priority encoder, line 3 highest.
// Ports:
//   act   in  4  active-high line vector
//   code  out 2  index of the highest set line (00 when none set)
//   any   out 1  at least one line set
//   multi out 1  two or more lines set
module yg_prio_enc4
  import yg_enc_pkg::*;
(
  input  logic [NUM_LINES-1:0] act,
  output logic [CODE_W-1:0]    code,
  output logic                 any,
  output logic                 multi
);

  always_comb begin
    code = 2'b00;
    casez (act)
      4'b1???: code = 2'b11;
      4'b01??: code = 2'b10;
      4'b001?: code = 2'b01;
      default: code = 2'b00;
    endcase
  end

  assign any = |act;

  // More than one bit set <=> clearing the lowest set bit leaves something.
  assign multi = |(act & (act - 4'd1));

endmodule

// File: rtl/yg_dec_encoder.sv
// Sequential 4-to-2 priority encoder recovering the select code from the
// active-low outputs of a 2x4 decoder, with a valid/ready output word.
// Ports:
//   clk        in       clock, rising edge
//   rst        in       synchronous active-high reset
//   en         in       positive enable; 0 masks all lines
//   y_n        in  4    decoder lines, active low
//   code       out 2    encoded highest active line of the pending word
//   out_valid  out 1    a word is pending
//   out_ready  in  1    consumer accepts the pending word
//   any_active out 1    registered OR of active lines
//   multi_err  out 1    registered: two or more lines active
//   overrun    out 1    sticky: new event arrived while a word was pending
//   evt_count  out CNT_W saturating count of accepted handshakes
module yg_dec_encoder
  import yg_enc_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [3:0]       y_n,
  output logic [1:0]       code,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             any_active,
  output logic             multi_err,
  output logic             overrun,
  output logic [CNT_W-1:0] evt_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [NUM_LINES-1:0] r_y_q;
  logic                 r_en_q;
  logic [NUM_LINES-1:0] r_act_prev;
  enc_state_t           r_state;
  enc_state_t           w_state_next;
  logic [CODE_W-1:0]    r_code;
  logic                 r_any;
  logic                 r_multi;
  logic                 r_overrun;
  logic [CNT_W-1:0]     r_cnt;

  logic [NUM_LINES-1:0] w_act;
  logic [CODE_W-1:0]    w_code_next;
  logic                 w_any;
  logic                 w_multi;
  logic                 w_new_evt;
  logic                 w_load;
  logic                 w_set_ovr;
  logic                 w_inc;

  // Input stage: register raw lines and enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_y_q  <= 4'b1111;
      r_en_q <= 1'b0;
    end else begin
      r_y_q  <= y_n;
      r_en_q <= en;
    end
  end

  assign w_act = ~r_y_q & {NUM_LINES{r_en_q}};

  yg_prio_enc4 u_prio (
    .act   (w_act),
    .code  (w_code_next),
    .any   (w_any),
    .multi (w_multi)
  );

  // A steady pattern yields exactly one event; returning to zero yields none.
  assign w_new_evt = w_any && (w_act != r_act_prev);

  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_set_ovr    = 1'b0;
    w_inc        = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_new_evt) begin
          w_load       = 1'b1;
          w_state_next = PRESENT;
        end
      end
      PRESENT: begin
        if (out_ready) begin
          w_inc = 1'b1;
          if (w_new_evt) begin
            // Handshake and reload in the same cycle keeps the word stream gapless.
            w_load       = 1'b1;
            w_state_next = PRESENT;
          end else begin
            w_state_next = IDLE;
          end
        end else if (w_new_evt) begin
          // Pending word wins; the new event is dropped and flagged.
          w_set_ovr = 1'b1;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // FSM / output stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_code     <= 2'b00;
      r_act_prev <= 4'b0000;
      r_any      <= 1'b0;
      r_multi    <= 1'b0;
      r_overrun  <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_state    <= w_state_next;
      r_act_prev <= w_act;
      r_any      <= w_any;
      r_multi    <= w_multi;
      if (w_load)
        r_code <= w_code_next;
      if (w_set_ovr)
        r_overrun <= 1'b1;
      if (w_inc && (r_cnt != CNT_MAX))
        r_cnt <= r_cnt + CNT_ONE;
    end
  end

  assign code       = r_code;
  assign out_valid  = (r_state == PRESENT);
  assign any_active = r_any;
  assign multi_err  = r_multi;
  assign overrun    = r_overrun;
  assign evt_count  = r_cnt;

endmodule
